// File: rtl/if_id_stage_buffer.sv
// Two-entry skid-buffered IF/ID pipeline register with flush support.
// Head entry drives decode directly; the skid entry absorbs one beat while decode stalls.
module if_id_stage_buffer #(
    parameter int unsigned         DATA_W    = 32,
    parameter logic [DATA_W-1:0]   NOP_INSTN = '0,
    parameter int unsigned         CNT_W     = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] inp_instn,
    input  logic [DATA_W-1:0] pc_to_branch,
    input  logic [DATA_W-1:0] nextpc,
    input  logic              fetch_valid,
    output logic              stall_flag,
    output logic              fetch_ready,
    input  logic              id_ready,
    input  logic              flush,
    output logic              id_valid,
    output logic [DATA_W-1:0] id_instn,
    output logic [DATA_W-1:0] id_pc,
    output logic [DATA_W-1:0] id_nextpc,
    output logic [CNT_W-1:0]  flush_count
);

    logic [DATA_W-1:0] h_instn_q, h_instn_d;
    logic [DATA_W-1:0] h_pc_q, h_pc_d;
    logic [DATA_W-1:0] h_nextpc_q, h_nextpc_d;
    logic              h_valid_q, h_valid_d;
    logic [DATA_W-1:0] s_instn_q, s_instn_d;
    logic [DATA_W-1:0] s_pc_q, s_pc_d;
    logic [DATA_W-1:0] s_nextpc_q, s_nextpc_d;
    logic              s_valid_q, s_valid_d;
    logic              fetch_ready_q, fetch_ready_d;
    logic [CNT_W-1:0]  flush_count_q, flush_count_d;

    logic              push;
    logic              pop;
    logic [1:0]        drop_cnt;
    logic [CNT_W+1:0]  cnt_sum;

    assign push = fetch_valid & fetch_ready_q;
    assign pop  = h_valid_q & id_ready;

    assign drop_cnt = {1'b0, h_valid_q} + {1'b0, s_valid_q};
    assign cnt_sum  = {2'b00, flush_count_q} + {{CNT_W{1'b0}}, drop_cnt};

    always_comb begin
        h_instn_d     = h_instn_q;
        h_pc_d        = h_pc_q;
        h_nextpc_d    = h_nextpc_q;
        h_valid_d     = h_valid_q;
        s_instn_d     = s_instn_q;
        s_pc_d        = s_pc_q;
        s_nextpc_d    = s_nextpc_q;
        s_valid_d     = s_valid_q;
        flush_count_d = flush_count_q;

        if (flush) begin
            // Flush wins over push and pop; the incoming beat is dropped uncounted.
            h_instn_d  = NOP_INSTN;
            h_pc_d     = '0;
            h_nextpc_d = '0;
            h_valid_d  = 1'b0;
            s_valid_d  = 1'b0;
            if (cnt_sum > {2'b00, {CNT_W{1'b1}}}) begin
                flush_count_d = {CNT_W{1'b1}};
            end else begin
                flush_count_d = cnt_sum[CNT_W-1:0];
            end
        end else if (!h_valid_q) begin
            if (push) begin
                h_instn_d  = inp_instn;
                h_pc_d     = pc_to_branch;
                h_nextpc_d = nextpc;
                h_valid_d  = 1'b1;
            end
        end else if (!s_valid_q) begin
            if (push && pop) begin
                h_instn_d  = inp_instn;
                h_pc_d     = pc_to_branch;
                h_nextpc_d = nextpc;
            end else if (push) begin
                s_instn_d  = inp_instn;
                s_pc_d     = pc_to_branch;
                s_nextpc_d = nextpc;
                s_valid_d  = 1'b1;
            end else if (pop) begin
                h_instn_d  = NOP_INSTN;
                h_pc_d     = '0;
                h_nextpc_d = '0;
                h_valid_d  = 1'b0;
            end
        end else if (pop) begin
            h_instn_d  = s_instn_q;
            h_pc_d     = s_pc_q;
            h_nextpc_d = s_nextpc_q;
            s_valid_d  = 1'b0;
        end

        fetch_ready_d = ~(h_valid_d & s_valid_d);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            h_instn_q     <= NOP_INSTN;
            h_pc_q        <= '0;
            h_nextpc_q    <= '0;
            h_valid_q     <= 1'b0;
            s_instn_q     <= '0;
            s_pc_q        <= '0;
            s_nextpc_q    <= '0;
            s_valid_q     <= 1'b0;
            fetch_ready_q <= 1'b1;
            flush_count_q <= '0;
        end else begin
            h_instn_q     <= h_instn_d;
            h_pc_q        <= h_pc_d;
            h_nextpc_q    <= h_nextpc_d;
            h_valid_q     <= h_valid_d;
            s_instn_q     <= s_instn_d;
            s_pc_q        <= s_pc_d;
            s_nextpc_q    <= s_nextpc_d;
            s_valid_q     <= s_valid_d;
            fetch_ready_q <= fetch_ready_d;
            flush_count_q <= flush_count_d;
        end
    end

    assign id_valid    = h_valid_q;
    assign id_instn    = h_instn_q;
    assign id_pc       = h_pc_q;
    assign id_nextpc   = h_nextpc_q;
    assign fetch_ready = fetch_ready_q;
    assign stall_flag  = ~fetch_ready_q;
    assign flush_count = flush_count_q;

endmodule

// File: tb/tb_if_id_stage_buffer.sv
// Directed bench for if_id_stage_buffer; a second instance with a 2-bit counter
// shares the stimulus to exercise flush-count saturation.
module tb_if_id_stage_buffer;

    logic        clk;
    logic        reset;
    logic [31:0] inp_instn;
    logic [31:0] pc_to_branch;
    logic [31:0] nextpc;
    logic        fetch_valid;
    logic        id_ready;
    logic        flush;

    logic        stall_flag, fetch_ready, id_valid;
    logic [31:0] id_instn, id_pc, id_nextpc;
    logic [7:0]  flush_count;

    logic        sm_stall_flag, sm_fetch_ready, sm_id_valid;
    logic [31:0] sm_id_instn, sm_id_pc, sm_id_nextpc;
    logic [1:0]  sm_flush_count;

    int n_checks = 0;
    int n_errors = 0;

    if_id_stage_buffer #(.DATA_W(32), .NOP_INSTN(32'h0000_0000), .CNT_W(8)) u_dut (
        .clk          (clk),
        .reset        (reset),
        .inp_instn    (inp_instn),
        .pc_to_branch (pc_to_branch),
        .nextpc       (nextpc),
        .fetch_valid  (fetch_valid),
        .stall_flag   (stall_flag),
        .fetch_ready  (fetch_ready),
        .id_ready     (id_ready),
        .flush        (flush),
        .id_valid     (id_valid),
        .id_instn     (id_instn),
        .id_pc        (id_pc),
        .id_nextpc    (id_nextpc),
        .flush_count  (flush_count)
    );

    if_id_stage_buffer #(.DATA_W(32), .NOP_INSTN(32'h0000_0000), .CNT_W(2)) u_dut_sm (
        .clk          (clk),
        .reset        (reset),
        .inp_instn    (inp_instn),
        .pc_to_branch (pc_to_branch),
        .nextpc       (nextpc),
        .fetch_valid  (fetch_valid),
        .stall_flag   (sm_stall_flag),
        .fetch_ready  (sm_fetch_ready),
        .id_ready     (id_ready),
        .flush        (flush),
        .id_valid     (sm_id_valid),
        .id_instn     (sm_id_instn),
        .id_pc        (sm_id_pc),
        .id_nextpc    (sm_id_nextpc),
        .flush_count  (sm_flush_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic beat(input logic [31:0] pc);
        fetch_valid  = 1'b1;
        pc_to_branch = pc;
        nextpc       = pc + 32'd4;
        inp_instn    = 32'h1000_0000 | pc;
    endtask

    task automatic check_head(input string tag, input logic [31:0] pc);
        check({tag, "_valid"}, 32'(id_valid), 32'd1);
        check({tag, "_pc"}, id_pc, pc);
        check({tag, "_instn"}, id_instn, 32'h1000_0000 | pc);
        check({tag, "_nextpc"}, id_nextpc, pc + 32'd4);
    endtask

    initial begin
        reset = 1'b0;
        inp_instn = '0; pc_to_branch = '0; nextpc = '0;
        fetch_valid = 1'b0; id_ready = 1'b0; flush = 1'b0;
        tick();
        tick();

        check("rst_id_valid", 32'(id_valid), 32'd0);
        check("rst_id_instn", id_instn, 32'h0);
        check("rst_id_pc", id_pc, 32'h0);
        check("rst_id_nextpc", id_nextpc, 32'h0);
        check("rst_fetch_ready", 32'(fetch_ready), 32'd1);
        check("rst_stall", 32'(stall_flag), 32'd0);
        check("rst_flush_count", 32'(flush_count), 32'd0);

        // Single beat after reset release
        reset = 1'b1;
        fetch_valid = 1'b1; inp_instn = 32'h2008_0005; pc_to_branch = 32'd0; nextpc = 32'd4;
        #1;
        check("single_pre_instn", id_instn, 32'h0);
        check("single_pre_valid", 32'(id_valid), 32'd0);
        tick();
        check("single_valid", 32'(id_valid), 32'd1);
        check("single_instn", id_instn, 32'h2008_0005);
        check("single_pc", id_pc, 32'd0);
        check("single_nextpc", id_nextpc, 32'd4);
        fetch_valid = 1'b0; id_ready = 1'b1;
        tick();
        check("single_pop_valid", 32'(id_valid), 32'd0);
        check("single_pop_instn", id_instn, 32'h0);

        // Decode stall fill
        id_ready = 1'b0;
        beat(32'd0);
        tick();
        check_head("fill0", 32'd0);
        check("fill0_ready", 32'(fetch_ready), 32'd1);
        beat(32'd4);
        tick();
        check_head("fill1", 32'd0);
        check("fill1_ready", 32'(fetch_ready), 32'd0);
        check("fill1_stall", 32'(stall_flag), 32'd1);
        beat(32'd8);
        tick();
        check_head("fill2_held", 32'd0);
        check("fill2_stall", 32'(stall_flag), 32'd1);
        id_ready = 1'b1;
        tick();
        check_head("drain_pc4", 32'd4);
        check("drain_pc4_ready", 32'(fetch_ready), 32'd1);
        tick();
        check_head("drain_pc8", 32'd8);
        fetch_valid = 1'b0;
        tick();
        check("drain_empty", 32'(id_valid), 32'd0);

        // Streaming: one entry per cycle, no stall
        for (int i = 0; i < 10; i++) begin
            beat(32'(4 * i));
            tick();
            check("stream_pc", id_pc, 32'(4 * i));
            check("stream_stall", 32'(stall_flag), 32'd0);
        end
        fetch_valid = 1'b0;
        tick();
        check("stream_empty", 32'(id_valid), 32'd0);

        // Flush with full buffer plus incoming beat, three times
        id_ready = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            beat(32'd16);
            tick();
            beat(32'd20);
            tick();
            check("fl_full_stall", 32'(stall_flag), 32'd1);
            beat(32'd24);
            flush = 1'b1;
            tick();
            flush = 1'b0;
            fetch_valid = 1'b0;
            check("fl_valid", 32'(id_valid), 32'd0);
            check("fl_instn", id_instn, 32'h0);
            check("fl_pc", id_pc, 32'h0);
            check("fl_ready", 32'(fetch_ready), 32'd1);
            check("fl_count", 32'(flush_count), 32'(2 * k));
            check("fl_count_sat", 32'(sm_flush_count), (k == 1) ? 32'd2 : 32'd3);
            tick();
            check("fl_no_pc24", 32'(id_valid), 32'd0);
        end

        // Flush with nothing buffered counts nothing
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check("fl_empty_count", 32'(flush_count), 32'd6);

        // Asynchronous reset between edges
        beat(32'd40);
        tick();
        beat(32'd44);
        tick();
        fetch_valid = 1'b0;
        check("ar_pre_stall", 32'(stall_flag), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        check("ar_valid", 32'(id_valid), 32'd0);
        check("ar_ready", 32'(fetch_ready), 32'd1);
        check("ar_stall", 32'(stall_flag), 32'd0);
        check("ar_count", 32'(flush_count), 32'd0);
        check("ar_count_sm", 32'(sm_flush_count), 32'd0);
        check("ar_instn", id_instn, 32'h0);
        tick();
        reset = 1'b1;
        beat(32'd48);
        tick();
        check_head("ar_first_push", 32'd48);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
